// File: rtl/io_cnt_pkg.sv
// Shared definitions for the counter-packet collector: type encodings, FSM states and
// helpers that derive field offsets from the configured widths.
package io_cnt_pkg;

  typedef enum logic [1:0] {
    CntStall = 2'd0,
    CntRead  = 2'd1,
    CntEmpty = 2'd2,
    CntFull  = 2'd3
  } cnt_type_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam int unsigned CntBits  = 16;
  localparam int unsigned TypeBits = 2;

  function automatic int unsigned val_bits(input int unsigned payload_bits,
                                           input int unsigned leaf_bits,
                                           input int unsigned port_bits);
    return payload_bits - TypeBits - leaf_bits - port_bits;
  endfunction

  // LSB positions of the routing fields in the packet word (valid bit is the MSB).
  function automatic int unsigned dst_leaf_lsb(input int unsigned packet_bits,
                                               input int unsigned leaf_bits);
    return packet_bits - 1 - leaf_bits;
  endfunction

  function automatic int unsigned dst_port_lsb(input int unsigned packet_bits,
                                               input int unsigned leaf_bits,
                                               input int unsigned port_bits);
    return packet_bits - 1 - leaf_bits - port_bits;
  endfunction

  // LSB positions of the source fields inside the payload (and hence inside a record).
  function automatic int unsigned src_leaf_lsb(input int unsigned payload_bits,
                                               input int unsigned leaf_bits);
    return payload_bits - TypeBits - leaf_bits;
  endfunction

  function automatic int unsigned src_port_lsb(input int unsigned payload_bits,
                                               input int unsigned leaf_bits,
                                               input int unsigned port_bits);
    return payload_bits - TypeBits - leaf_bits - port_bits;
  endfunction

endpackage

// File: rtl/io_cnt_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded counter records.
module io_cnt_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrBits = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned Depth = 1 << AddrBits;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrBits:0] wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  // Extra MSB on each pointer tells a full ring from an empty one.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrBits] != rd_ptr_q[AddrBits]) &&
                   (wr_ptr_q[AddrBits-1:0] == rd_ptr_q[AddrBits-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrBits-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrBits-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_cnt_collector.sv
// Collects counter packets addressed to this endpoint into a record FIFO and tracks
// accepted/dropped totals for one collection window.
module io_cnt_collector
  import io_cnt_pkg::*;
#(
  parameter int unsigned PACKET_BITS    = 49,
  parameter int unsigned NUM_LEAF_BITS  = 5,
  parameter int unsigned NUM_PORT_BITS  = 4,
  parameter int unsigned PAYLOAD_BITS   = 32,
  parameter int unsigned CNT_PORT       = 1,
  parameter int unsigned FIFO_ADDR_BITS = 4,
  localparam int unsigned VAL_BITS = val_bits(PAYLOAD_BITS, NUM_LEAF_BITS, NUM_PORT_BITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   stream_in,
  input  logic [NUM_LEAF_BITS-1:0] self_leaf,
  input  logic                     start,
  input  logic [CntBits-1:0]       expected_records,
  output logic                     rec_vld,
  input  logic                     rec_ack,
  output logic [TypeBits-1:0]      rec_type,
  output logic [NUM_LEAF_BITS-1:0] rec_leaf,
  output logic [NUM_PORT_BITS-1:0] rec_port,
  output logic [VAL_BITS-1:0]      rec_value,
  output logic [CntBits-1:0]       accepted_cnt,
  output logic [CntBits-1:0]       drop_cnt,
  output logic                     collect_done,
  output logic                     busy
);

  localparam int unsigned RecBits    = PAYLOAD_BITS;
  localparam int unsigned DstLeafLsb = dst_leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int unsigned DstPortLsb = dst_port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int unsigned SrcLeafLsb = src_leaf_lsb(PAYLOAD_BITS, NUM_LEAF_BITS);
  localparam int unsigned SrcPortLsb = src_port_lsb(PAYLOAD_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);

  state_e               state_q, state_d;
  logic [CntBits-1:0]   acc_q, acc_d, drop_q, drop_d;
  logic [CntBits:0]     total_d;
  logic                 done_q, busy_q;
  logic                 match, fifo_push, fifo_pop, fifo_empty, fifo_full, pkt_drop;
  logic [RecBits-1:0]   rec_rdata;
  logic                 unused_stream;

  // Reserved bits are don't-care; fold the whole word so none is left dangling.
  assign unused_stream = ^stream_in;

  assign match = stream_in[PACKET_BITS-1] &&
                 (stream_in[DstLeafLsb +: NUM_LEAF_BITS] == self_leaf) &&
                 (stream_in[DstPortLsb +: NUM_PORT_BITS] == NUM_PORT_BITS'(CNT_PORT));

  assign rec_vld   = !fifo_empty;
  assign fifo_pop  = rec_vld && rec_ack;
  assign fifo_push = (state_q == StCollect) && match && (!fifo_full || fifo_pop);
  assign pkt_drop  = match && (((state_q == StCollect) && !fifo_push) || (state_q == StDrain));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    drop_d  = drop_q;
    if (fifo_push && (acc_q != '1)) acc_d = acc_q + 1'b1;
    if (pkt_drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    total_d = {1'b0, acc_d} + {1'b0, drop_d};
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d   = '0;
          drop_d  = '0;
          state_d = (expected_records == '0) ? StDrain : StCollect;
        end
      end
      StCollect: if (total_d >= {1'b0, expected_records}) state_d = StDrain;
      StDrain:   if (fifo_empty) state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      done_q  <= (state_d == StDone);
      busy_q  <= (state_d == StCollect) || (state_d == StDrain);
    end
  end

  io_cnt_fifo #(
    .Width   (RecBits),
    .AddrBits(FIFO_ADDR_BITS)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (fifo_push),
    .wdata_i(stream_in[PAYLOAD_BITS-1:0]),
    .pop_i  (fifo_pop),
    .rdata_o(rec_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign rec_type     = rec_rdata[RecBits-1 -: TypeBits];
  assign rec_leaf     = rec_rdata[SrcLeafLsb +: NUM_LEAF_BITS];
  assign rec_port     = rec_rdata[SrcPortLsb +: NUM_PORT_BITS];
  assign rec_value    = rec_rdata[VAL_BITS-1:0];
  assign accepted_cnt = acc_q;
  assign drop_cnt     = drop_q;
  assign collect_done = done_q;
  assign busy         = busy_q;

endmodule
